// File: rtl/flopoco_pkg.sv
`default_nettype none
// flopoco_pkg: exception codes, default widths and word-width helpers for the
// FloPoCo encoder, comparator and unpack logic.
package flopoco_pkg;

  localparam logic [1:0] EXN_ZERO   = 2'b00;
  localparam logic [1:0] EXN_NORMAL = 2'b01;
  localparam logic [1:0] EXN_INF    = 2'b10;
  localparam logic [1:0] EXN_NAN    = 2'b11;

  localparam int DEF_WE = 11;
  localparam int DEF_WF = 14;

  function automatic int in_width(input int we, input int wf);
    return we + wf + 1;
  endfunction

  function automatic int out_width(input int we, input int wf);
    return we + wf + 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flopoco_exn_classify.sv
`default_nettype none
// flopoco_exn_classify: combinational exception classification of an IEEE-style
// float, with subnormal/NaN flags and the sign as it appears in FloPoCo form.
module flopoco_exn_classify
  import flopoco_pkg::*;
#(
  parameter int WE = DEF_WE,
  parameter int WF = DEF_WF
) (
  input  logic          sign_i,
  input  logic [WE-1:0] exp_i,
  input  logic [WF-1:0] frac_i,
  output logic [1:0]    exn_o,
  output logic          sign_o,
  output logic          is_subnormal_o,
  output logic          is_nan_o
);

  logic exp_zero_w;
  logic exp_ones_w;
  logic frac_nz_w;

  assign exp_zero_w = (exp_i == '0);
  assign exp_ones_w = &exp_i;
  assign frac_nz_w  = |frac_i;

  always_comb begin
    exn_o = EXN_NORMAL;
    if (exp_zero_w) begin
      exn_o = EXN_ZERO;
    end else if (exp_ones_w) begin
      exn_o = frac_nz_w ? EXN_NAN : EXN_INF;
    end
  end

  assign is_subnormal_o = exp_zero_w && frac_nz_w;
  assign is_nan_o       = exp_ones_w && frac_nz_w;
  // NaNs are canonicalised to a positive sign
  assign sign_o         = sign_i && !is_nan_o;

endmodule
`default_nettype wire

// File: rtl/flopoco_encode.sv
`default_nettype none
// flopoco_encode: two-stage valid/ready pipeline converting packed IEEE-style
// floats to FloPoCo words, with saturating subnormal-flush and NaN counters.
module flopoco_encode
  import flopoco_pkg::*;
#(
  parameter int WE = DEF_WE,
  parameter int WF = DEF_WF,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WE+WF:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WE+WF+2:0] out_data,
  input  logic            clr_cnt,
  output logic [CW-1:0]   flush_cnt,
  output logic [CW-1:0]   nan_cnt
);

  localparam int IW = in_width(WE, WF);
  localparam int OW = out_width(WE, WF);

  logic          s1_valid_q, s2_valid_q;
  logic [OW-1:0] s1_data_q, s2_data_q;
  logic [OW-1:0] s1_data_d;
  logic [CW-1:0] flush_q, flush_d;
  logic [CW-1:0] nan_q, nan_d;

  logic       adv1_w, adv2_w, accept_w;
  logic [1:0] exn_w;
  logic       sign_w, is_sub_w, is_nan_w;

  flopoco_exn_classify #(
    .WE(WE),
    .WF(WF)
  ) u_classify (
    .sign_i         (in_data[IW-1]),
    .exp_i          (in_data[IW-2:WF]),
    .frac_i         (in_data[WF-1:0]),
    .exn_o          (exn_w),
    .sign_o         (sign_w),
    .is_subnormal_o (is_sub_w),
    .is_nan_o       (is_nan_w)
  );

  assign adv2_w   = !s2_valid_q || out_ready;
  assign adv1_w   = !s1_valid_q || adv2_w;
  assign accept_w = in_valid && adv1_w;

  // Only normal numbers carry exponent and fraction; all specials zero them
  assign s1_data_d = {exn_w, sign_w,
                      (exn_w == EXN_NORMAL) ? in_data[IW-2:0] : {(IW-1){1'b0}}};

  always_comb begin
    flush_d = flush_q;
    nan_d   = nan_q;
    if (clr_cnt) begin
      flush_d = '0;
      nan_d   = '0;
    end else if (accept_w) begin
      if (is_sub_w && (flush_q != '1)) flush_d = flush_q + CW'(1);
      if (is_nan_w && (nan_q != '1))   nan_d   = nan_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_data_q  <= '0;
      flush_q    <= '0;
      nan_q      <= '0;
    end else begin
      if (adv2_w) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
      if (adv1_w) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_data_q <= s1_data_d;
      end
      flush_q <= flush_d;
      nan_q   <= nan_d;
    end
  end

  assign in_ready  = adv1_w;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign flush_cnt = flush_q;
  assign nan_cnt   = nan_q;

endmodule
`default_nettype wire
